mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port synchronous word RAM between the core's instruction-fetch
//  port and its load/store port, for the unified-memory build of the core.
//  One transaction in flight at a time. Data accesses have priority; a defer counter
//  bounds fetch starvation. Read latency to the requester is RAM_LAT+1 cycles.
// PARAMETERS
//  ADDR_W     10  word-address width (word index, byte address [11:2])
//  DATA_W     32  data width
//  RAM_LAT    1   RAM read latency in cycles, legal 1..3
//  MAX_DEFER  4   max consecutive data grants while if_req waits, legal 1..15
// PORTS
//  CLK        in   1       clock, all state on posedge
//  RSTn       in   1       asynchronous active-low reset
//  if_req     in   1       fetch read request
//  if_addr    in   ADDR_W  fetch word address
//  if_gnt     out  1       fetch request accepted this cycle
//  if_rvalid  out  1       fetch read data valid, 1-cycle pulse
//  if_rdata   out  DATA_W  fetch read data, held until next fetch response
//  d_req      in   1       data request
//  d_we       in   1       1 = write, 0 = read
//  d_addr     in   ADDR_W  data word address
//  d_wdata    in   DATA_W  store data
//  d_gnt      out  1       data request accepted this cycle
//  d_rvalid   out  1       load data valid, 1-cycle pulse (reads only)
//  d_rdata    out  DATA_W  load data, held until next data read response
//  ram_en     out  1       RAM access strobe
//  ram_we     out  1       RAM write enable
//  ram_addr   out  ADDR_W  RAM word address
//  ram_wdata  out  DATA_W  RAM write data
//  ram_rdata  in   DATA_W  RAM read data, valid RAM_LAT cycles after ram_en
// BEHAVIOUR
//  Reset: state IDLE, wait counter 0, defer counter 0, owner 0, if_rdata/d_rdata 0,
//   rvalids 0. While RSTn low, gnts, ram_en, ram_we forced 0; ram_addr/ram_wdata 0.
//  FSM: IDLE, WAIT. Grants issued only in IDLE (combinational from req in that cycle).
//  Arbitration in IDLE:
//   - only one req -> that port wins.
//   - both req, defer < MAX_DEFER -> data wins, defer++.
//   - both req, defer == MAX_DEFER -> fetch wins.
//   - any fetch grant, or if_req low in an arbitration cycle -> defer <= 0.
//  Grant cycle T: winner gnt=1, ram_en=1, ram_addr=winner addr; ram_we=d_we and
//   ram_wdata=d_wdata only when data wins, else ram_we=0, ram_wdata=0.
//  No grant: ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0.
//  Write: completes at T, no rvalid, stays IDLE; next grant possible at T+1.
//  Read: owner latched, IDLE->WAIT, counter=RAM_LAT. WAIT cycles T+1..T+RAM_LAT,
//   no grants. Counter decrements each WAIT cycle.
//  Counter==1: ram_rdata captured into owner's rdata register; ->IDLE.
//  Cycle T+RAM_LAT+1: owner rvalid=1 with new rdata. Arbitration for a new grant
//   runs in that same cycle.
//  Read throughput: one per RAM_LAT+1 cycles; write throughput: one per cycle.
//  Requester rule: req, addr, we and wdata held stable until gnt is seen. Dropping
//   req before gnt is legal and cancels the request with no RAM access.
//  Requests arriving during WAIT are not sampled until IDLE.
//  Reset mid-WAIT: in-flight read abandoned, no rvalid ever issued for it.
//  Never both gnts in a cycle; never both rvalids in a cycle.
// TESTING
//  1 Fetch read, RAM_LAT=1: if_req, if_addr=0x010 at T; ram_rdata=0x00500093 at T+1
//    -> if_gnt=1 and ram_en=1 at T; if_rvalid=1 with if_rdata=0x00500093 at T+2.
//  2 Both req reads at T, d_addr=0x020, if_addr=0x004 -> d_gnt at T; d_rvalid at T+2;
//    if_gnt at T+2; if_rvalid at T+4.
//  3 Starvation: d_req writes held continuously and if_req held from T, MAX_DEFER=4
//    -> d_gnt at T..T+3; if_gnt at T+4; d_gnt resumes at T+6.
//  4 Write: d_we=1, d_addr=0x3FF, d_wdata=0xDEADBEEF -> same cycle ram_we=1,
//    ram_addr=0x3FF, ram_wdata=0xDEADBEEF; d_rvalid stays 0; second write granted next cycle.
//  5 Reset mid-read: read granted at T, RSTn low at T+1 for 2 cycles
//    -> no rvalid; rdata regs 0; first request after release granted normally.
//  6 RAM_LAT=3, continuous fetch reads -> if_gnt every 4th cycle;
//    each if_rvalid 4 cycles after its grant.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port synchronous RAM between the fetch and load/store ports.
// One transaction in flight; data has priority, a defer counter bounds fetch starvation.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned RAM_LAT   = 1,
  parameter int unsigned MAX_DEFER = 4
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [3:0]        defer_q, defer_d;
  logic              owner_q, owner_d;  // 1 = data port owns the in-flight read
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic              d_rvalid_q, d_rvalid_d;
  logic              grant_if, grant_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    defer_d     = defer_q;
    owner_d     = owner_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    grant_if    = 1'b0;
    grant_d     = 1'b0;
    ram_en      = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = '0;
    ram_wdata   = '0;

    unique case (state_q)
      StIdle: begin
        // Grant outputs are forced low while reset is asserted.
        if (RSTn) begin
          if (d_req && (!if_req || (defer_q < 4'(MAX_DEFER)))) begin
            grant_d = 1'b1;
          end else if (if_req) begin
            grant_if = 1'b1;
          end
        end

        if (if_req && grant_d) begin
          defer_d = defer_q + 4'd1;
        end else begin
          defer_d = '0;
        end

        if (grant_d) begin
          ram_en    = 1'b1;
          ram_we    = d_we;
          ram_addr  = d_addr;
          ram_wdata = d_wdata;
        end else if (grant_if) begin
          ram_en   = 1'b1;
          ram_addr = if_addr;
        end

        if (grant_if || (grant_d && !d_we)) begin
          state_d = StWait;
          cnt_d   = 2'(RAM_LAT);
          owner_d = grant_d;
        end
      end

      StWait: begin
        if (cnt_q == 2'd1) begin
          state_d = StIdle;
          if (owner_q) begin
            d_rdata_d  = ram_rdata;
            d_rvalid_d = 1'b1;
          end else begin
            if_rdata_d  = ram_rdata;
            if_rvalid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      defer_q     <= '0;
      owner_q     <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      defer_q     <= defer_d;
      owner_q     <= owner_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
    end
  end

  assign if_gnt    = grant_if;
  assign d_gnt     = grant_d;
  assign if_rvalid = if_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed stimulus, read responses checked by a scoreboard monitor.
// Two instances: RAM_LAT=1 for most scenarios, RAM_LAT=3 for the fetch-throughput scenario.
module tb_mem_port_arbiter;

  logic        CLK;
  logic        RSTn;

  logic        if_req, if_gnt, if_rvalid;
  logic [9:0]  if_addr;
  logic [31:0] if_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [9:0]  d_addr;
  logic [31:0] d_wdata, d_rdata;
  logic        ram_en, ram_we;
  logic [9:0]  ram_addr;
  logic [31:0] ram_wdata, ram_rdata;

  logic        if_req3, if_gnt3, if_rvalid3;
  logic [9:0]  if_addr3;
  logic [31:0] if_rdata3;
  logic        d_req3, d_we3, d_gnt3, d_rvalid3;
  logic [9:0]  d_addr3;
  logic [31:0] d_wdata3, d_rdata3;
  logic        ram_en3, ram_we3;
  logic [9:0]  ram_addr3;
  logic [31:0] ram_wdata3, ram_rdata3;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t q_if[$];
  exp_t q_d[$];
  exp_t q_if3[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  mem_port_arbiter #(.ADDR_W(10), .DATA_W(32), .RAM_LAT(1), .MAX_DEFER(4)) u_dut (
    .CLK(CLK), .RSTn(RSTn),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  mem_port_arbiter #(.ADDR_W(10), .DATA_W(32), .RAM_LAT(3), .MAX_DEFER(4)) u_dut3 (
    .CLK(CLK), .RSTn(RSTn),
    .if_req(if_req3), .if_addr(if_addr3), .if_gnt(if_gnt3),
    .if_rvalid(if_rvalid3), .if_rdata(if_rdata3),
    .d_req(d_req3), .d_we(d_we3), .d_addr(d_addr3), .d_wdata(d_wdata3),
    .d_gnt(d_gnt3), .d_rvalid(d_rvalid3), .d_rdata(d_rdata3),
    .ram_en(ram_en3), .ram_we(ram_we3), .ram_addr(ram_addr3),
    .ram_wdata(ram_wdata3), .ram_rdata(ram_rdata3)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Preloaded RAM contents; locations written through the port override these.
  function automatic logic [31:0] init_word(input logic [9:0] a);
    case (a)
      10'h010: return 32'h0050_0093;
      10'h020: return 32'h1111_2222;
      10'h004: return 32'h3333_4444;
      10'h008: return 32'h5555_6666;
      10'h040: return 32'hA000_0001;
      10'h041: return 32'hA000_0002;
      10'h042: return 32'hA000_0003;
      10'h043: return 32'hA000_0004;
      default: return 32'hEEEE_0000;
    endcase
  endfunction

  logic [31:0] mem1 [1024];
  bit          wr1  [1024];

  always @(posedge CLK) begin
    if (ram_en) begin
      if (ram_we) begin
        mem1[ram_addr] <= ram_wdata;
        wr1[ram_addr]  <= 1'b1;
      end else begin
        ram_rdata <= wr1[ram_addr] ? mem1[ram_addr] : init_word(ram_addr);
      end
    end
  end

  logic [31:0] p0, p1;
  always @(posedge CLK) begin
    if (ram_en3) p0 <= init_word(ram_addr3);
    p1         <= p0;
    ram_rdata3 <= p1;
  end

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever a DUT presents a read response.
  exp_t e;
  always @(negedge CLK) begin
    if (RSTn) begin
      if (if_rvalid) begin
        if (q_if.size() == 0) check1("if_rvalid unexpected", if_rvalid, 1'b0);
        else begin
          e = q_if.pop_front();
          check32("if_rdata", if_rdata, e.data);
          check32("if_rvalid cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      if (d_rvalid) begin
        if (q_d.size() == 0) check1("d_rvalid unexpected", d_rvalid, 1'b0);
        else begin
          e = q_d.pop_front();
          check32("d_rdata", d_rdata, e.data);
          check32("d_rvalid cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      if (if_rvalid3) begin
        if (q_if3.size() == 0) check1("if_rvalid3 unexpected", if_rvalid3, 1'b0);
        else begin
          e = q_if3.pop_front();
          check32("if_rdata3", if_rdata3, e.data);
          check32("if_rvalid3 cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      check1("dual gnt", if_gnt && d_gnt, 1'b0);
      check1("dual rvalid", if_rvalid && d_rvalid, 1'b0);
      check1("dut3 data side idle", d_gnt3 | d_rvalid3 | ram_we3, 1'b0);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic at_neg();
    @(negedge CLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RSTn     = 1'b0;
    if_req   = 1'b1;
    if_addr  = 10'h010;
    d_req    = 1'b1;
    d_we     = 1'b1;
    d_addr   = 10'h020;
    d_wdata  = 32'h5;
    if_req3  = 1'b0;
    if_addr3 = '0;
    d_req3   = 1'b0;
    d_we3    = 1'b0;
    d_addr3  = '0;
    d_wdata3 = '0;

    // Reset state, with both requests asserted to show grants are forced off.
    repeat (2) @(posedge CLK);
    at_neg();
    check1("rst if_gnt", if_gnt, 1'b0);
    check1("rst d_gnt", d_gnt, 1'b0);
    check1("rst ram_en", ram_en, 1'b0);
    check1("rst ram_we", ram_we, 1'b0);
    check32("rst ram_addr", 32'(ram_addr), 32'h0);
    check32("rst ram_wdata", ram_wdata, 32'h0);
    check32("rst if_rdata", if_rdata, 32'h0);
    check32("rst d_rdata", d_rdata, 32'h0);
    check1("rst if_rvalid", if_rvalid, 1'b0);
    check1("rst d_rvalid", d_rvalid, 1'b0);

    tick();
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_wdata = '0;
    RSTn = 1'b1;
    tick();

    // 1: single fetch read
    tick();
    if_req = 1'b1; if_addr = 10'h010;
    at_neg();
    check1("t1 if_gnt", if_gnt, 1'b1);
    check1("t1 d_gnt", d_gnt, 1'b0);
    check1("t1 ram_en", ram_en, 1'b1);
    check1("t1 ram_we", ram_we, 1'b0);
    check32("t1 ram_addr", 32'(ram_addr), 32'h010);
    q_if.push_back('{32'h0050_0093, cyc + 2});
    tick();
    if_req = 1'b0;
    at_neg();
    check1("t1 wait ram_en", ram_en, 1'b0);
    tick();
    tick();

    // 2: simultaneous reads, data first then fetch
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'h020;
    if_req = 1'b1; if_addr = 10'h004;
    at_neg();
    check1("t2 d_gnt", d_gnt, 1'b1);
    check1("t2 if_gnt lose", if_gnt, 1'b0);
    check32("t2 ram_addr d", 32'(ram_addr), 32'h020);
    q_d.push_back('{32'h1111_2222, cyc + 2});
    tick();
    d_req = 1'b0;
    at_neg();
    check1("t2 wait if_gnt", if_gnt, 1'b0);
    tick();
    at_neg();
    check1("t2 if_gnt", if_gnt, 1'b1);
    check32("t2 ram_addr if", 32'(ram_addr), 32'h004);
    q_if.push_back('{32'h3333_4444, cyc + 2});
    tick();
    if_req = 1'b0;
    tick();
    tick();

    // 3: starvation bound with back-to-back writes
    d_req = 1'b1; d_we = 1'b1; d_addr = 10'h100; d_wdata = 32'hC0DE_0000;
    if_req = 1'b1; if_addr = 10'h008;
    for (int i = 0; i < 4; i++) begin
      at_neg();
      check1("t3 d_gnt", d_gnt, 1'b1);
      check1("t3 if_gnt held off", if_gnt, 1'b0);
      check1("t3 ram_we", ram_we, 1'b1);
      check32("t3 ram_addr", 32'(ram_addr), 32'h100 + 32'(i));
      check32("t3 ram_wdata", ram_wdata, 32'hC0DE_0000 + 32'(i));
      tick();
      d_addr  = 10'h100 + 10'(i + 1);
      d_wdata = 32'hC0DE_0000 + 32'(i + 1);
    end
    at_neg();
    check1("t3 if_gnt at limit", if_gnt, 1'b1);
    check1("t3 d_gnt at limit", d_gnt, 1'b0);
    check1("t3 ram_we fetch", ram_we, 1'b0);
    check32("t3 ram_wdata fetch", ram_wdata, 32'h0);
    check32("t3 ram_addr fetch", 32'(ram_addr), 32'h008);
    q_if.push_back('{32'h5555_6666, cyc + 2});
    tick();
    if_req = 1'b0;
    at_neg();
    check1("t3 wait d_gnt", d_gnt, 1'b0);
    check1("t3 wait ram_en", ram_en, 1'b0);
    tick();
    at_neg();
    check1("t3 d_gnt resumes", d_gnt, 1'b1);
    check32("t3 ram_addr resume", 32'(ram_addr), 32'h104);

    // 4: writes at the top address, then read-back
    tick();
    d_addr = 10'h3FF; d_wdata = 32'hDEAD_BEEF;
    at_neg();
    check1("t4 d_gnt", d_gnt, 1'b1);
    check1("t4 ram_en", ram_en, 1'b1);
    check1("t4 ram_we", ram_we, 1'b1);
    check32("t4 ram_addr", 32'(ram_addr), 32'h3FF);
    check32("t4 ram_wdata", ram_wdata, 32'hDEAD_BEEF);
    tick();
    d_addr = 10'h3FE; d_wdata = 32'h0123_4567;
    at_neg();
    check1("t4 second write gnt", d_gnt, 1'b1);
    check32("t4 second ram_addr", 32'(ram_addr), 32'h3FE);
    check1("t4 no d_rvalid", d_rvalid, 1'b0);
    tick();
    d_we = 1'b0; d_addr = 10'h3FF;
    at_neg();
    check1("t4 read gnt", d_gnt, 1'b1);
    check1("t4 read ram_we", ram_we, 1'b0);
    q_d.push_back('{32'hDEAD_BEEF, cyc + 2});
    tick();
    d_addr = 10'h102;
    at_neg();
    check1("t4 wait d_gnt", d_gnt, 1'b0);
    tick();
    at_neg();
    check1("t4 back-to-back read gnt", d_gnt, 1'b1);
    check32("t4 read ram_addr", 32'(ram_addr), 32'h102);
    q_d.push_back('{32'hC0DE_0002, cyc + 2});
    tick();
    d_req = 1'b0;
    tick();
    tick();

    // 5: reset in the middle of a read
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'h020;
    at_neg();
    check1("t5 d_gnt", d_gnt, 1'b1);
    tick();
    d_req = 1'b0; if_req = 1'b1; if_addr = 10'h010;
    RSTn = 1'b0;
    at_neg();
    check32("t5 d_rdata cleared", d_rdata, 32'h0);
    check32("t5 if_rdata cleared", if_rdata, 32'h0);
    check1("t5 if_gnt in reset", if_gnt, 1'b0);
    check1("t5 ram_en in reset", ram_en, 1'b0);
    tick();
    at_neg();
    check1("t5 d_rvalid in reset", d_rvalid, 1'b0);
    tick();
    RSTn = 1'b1;
    at_neg();
    check1("t5 gnt after release", if_gnt, 1'b1);
    check32("t5 ram_addr after release", 32'(ram_addr), 32'h010);
    q_if.push_back('{32'h0050_0093, cyc + 2});
    tick();
    if_req = 1'b0;
    repeat (3) tick();
    check32("t5 d_rdata stays 0", d_rdata, 32'h0);

    // 6: RAM_LAT=3, continuous fetch reads
    if_req3 = 1'b1; if_addr3 = 10'h040;
    for (int k = 0; k < 4; k++) begin
      at_neg();
      check1("t6 if_gnt3", if_gnt3, 1'b1);
      check32("t6 ram_addr3", 32'(ram_addr3), 32'h040 + 32'(k));
      case (k)
        0: q_if3.push_back('{32'hA000_0001, cyc + 4});
        1: q_if3.push_back('{32'hA000_0002, cyc + 4});
        2: q_if3.push_back('{32'hA000_0003, cyc + 4});
        default: q_if3.push_back('{32'hA000_0004, cyc + 4});
      endcase
      for (int j = 0; j < 3; j++) begin
        tick();
        if (j == 0) if_addr3 = 10'h040 + 10'(k + 1);
        at_neg();
        check1("t6 if_gnt3 wait", if_gnt3, 1'b0);
      end
      tick();
    end
    if_req3 = 1'b0;
    repeat (6) tick();

    check32("if queue drained", 32'(q_if.size()), 32'h0);
    check32("d queue drained", 32'(q_d.size()), 32'h0);
    check32("if3 queue drained", 32'(q_if3.size()), 32'h0);
    check32("dut3 d_rdata", d_rdata3, 32'h0);
    check32("dut3 ram_wdata idle", ram_wdata3, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
